// File: rtl/pool2_ctrl_if.sv
// Control and address bundle between pool2_ctrl, the f4/f5 RAMs and the 16 pool units.
// The pool2_abort wire exists only when POOL2_ABORT_EN is defined.
interface pool2_ctrl_if #(
  parameter int AW_IN  = 7,
  parameter int AW_OUT = 5
);
  logic              pool2_start;
  logic              pool2_busy;
  logic              pool2_done;
  logic              f4_ren;
  logic [AW_IN-1:0]  f4_raddr;
  logic              pool2_clr;
  logic              f5_wen;
  logic [AW_OUT-1:0] f5_waddr;
`ifdef POOL2_ABORT_EN
  logic              pool2_abort;
`endif

  modport master (
    input  pool2_start,
`ifdef POOL2_ABORT_EN
    input  pool2_abort,
`endif
    output pool2_busy, pool2_done, f4_ren, f4_raddr, pool2_clr, f5_wen, f5_waddr
  );

  modport slave (
    output pool2_start,
`ifdef POOL2_ABORT_EN
    output pool2_abort,
`endif
    input  pool2_busy, pool2_done, f4_ren, f4_raddr, pool2_clr, f5_wen, f5_waddr
  );
endinterface

// File: rtl/pool2_ctrl.sv
// Layer-2 pooling sequencer: reads f4 in 2x2-window order, steers the pool units, writes f5.
// Optional run abort input is compiled in with `define POOL2_ABORT_EN.
module pool2_ctrl #(
  parameter int IN_DIM  = 10,
  parameter int OUT_DIM = 5,
  parameter int AW_IN   = 7,
  parameter int AW_OUT  = 5,
  parameter int RD_LAT  = 1
) (
  input logic          clk,
  input logic          rst_n,
  pool2_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  localparam logic [AW_OUT-1:0] LAST_W = AW_OUT'(OUT_DIM - 1);
  localparam logic [AW_OUT-1:0] LAST_K = AW_OUT'(OUT_DIM * OUT_DIM - 1);
  localparam logic [AW_OUT-1:0] ONE_O  = AW_OUT'(1);
  localparam logic [AW_IN-1:0]  ROW_W  = AW_IN'(IN_DIM);

  state_t            state;
  logic [AW_OUT-1:0] wr, wc, win;
  logic [AW_OUT-1:0] nxt_wr, nxt_wc, nxt_win;
  logic [1:0]        sub, nxt_sub;
  logic              last_read;
  logic              abort_hit;
  logic [RD_LAT:0]   dl_first, dl_last;
  logic [AW_OUT-1:0] dl_idx [0:RD_LAT];

  function automatic logic [AW_IN-1:0] addr_of(input logic [AW_OUT-1:0] r,
                                               input logic [AW_OUT-1:0] c,
                                               input logic [1:0] s);
    logic [AW_IN-1:0] row, col;
    row = AW_IN'({r, s[1]});
    col = AW_IN'({c, s[0]});
    return row * ROW_W + col;
  endfunction

  always_comb begin
    nxt_sub = sub + 2'd1;
    nxt_wc  = wc;
    nxt_wr  = wr;
    nxt_win = win;
    if (sub == 2'd3) begin
      nxt_win = win + ONE_O;
      if (wc == LAST_W) begin
        nxt_wc = '0;
        nxt_wr = wr + ONE_O;
      end else begin
        nxt_wc = wc + ONE_O;
      end
    end
  end

  assign last_read = (sub == 2'd3) && (wc == LAST_W) && (wr == LAST_W);

`ifdef POOL2_ABORT_EN
  assign abort_hit = bus.pool2_abort && (state == READ || state == DRAIN);
`else
  assign abort_hit = 1'b0;
`endif

  // dl_* stage 0 describes the read on the bus this cycle; stage i is that read i cycles later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      wr             <= '0;
      wc             <= '0;
      win            <= '0;
      sub            <= '0;
      dl_first       <= '0;
      dl_last        <= '0;
      for (int i = 0; i <= RD_LAT; i++) dl_idx[i] <= '0;
      bus.pool2_busy <= 1'b0;
      bus.pool2_done <= 1'b0;
      bus.f4_ren     <= 1'b0;
      bus.f4_raddr   <= '0;
      bus.pool2_clr  <= 1'b0;
      bus.f5_wen     <= 1'b0;
      bus.f5_waddr   <= '0;
    end else if (abort_hit) begin
      state          <= IDLE;
      dl_first       <= '0;
      dl_last        <= '0;
      bus.pool2_busy <= 1'b0;
      bus.pool2_done <= 1'b0;
      bus.f4_ren     <= 1'b0;
      bus.pool2_clr  <= 1'b0;
      bus.f5_wen     <= 1'b0;
    end else begin
      for (int i = 1; i <= RD_LAT; i++) begin
        dl_first[i] <= dl_first[i-1];
        dl_last[i]  <= dl_last[i-1];
        dl_idx[i]   <= dl_idx[i-1];
      end
      dl_first[0]    <= 1'b0;
      dl_last[0]     <= 1'b0;
      bus.pool2_clr  <= dl_first[RD_LAT-1];
      bus.f5_wen     <= dl_last[RD_LAT];
      if (dl_last[RD_LAT]) bus.f5_waddr <= dl_idx[RD_LAT];
      bus.pool2_done <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.pool2_start) begin
            state          <= READ;
            bus.pool2_busy <= 1'b1;
            bus.f4_ren     <= 1'b1;
            bus.f4_raddr   <= '0;
            wr             <= '0;
            wc             <= '0;
            win            <= '0;
            sub            <= '0;
            dl_first[0]    <= 1'b1;
            dl_idx[0]      <= '0;
          end
        end
        READ: begin
          if (last_read) begin
            state      <= DRAIN;
            bus.f4_ren <= 1'b0;
          end else begin
            wr           <= nxt_wr;
            wc           <= nxt_wc;
            win          <= nxt_win;
            sub          <= nxt_sub;
            bus.f4_raddr <= addr_of(nxt_wr, nxt_wc, nxt_sub);
            dl_first[0]  <= (nxt_sub == 2'd0);
            dl_last[0]   <= (nxt_sub == 2'd3);
            dl_idx[0]    <= nxt_win;
          end
        end
        DRAIN: begin
          // The last window's write is on the bus this cycle; finish next cycle.
          if (bus.f5_wen && bus.f5_waddr == LAST_K) begin
            state          <= DONE;
            bus.pool2_done <= 1'b1;
          end
        end
        DONE: begin
          state          <= IDLE;
          bus.pool2_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pool2_ctrl.sv
// Self-checking bench for pool2_ctrl: per-cycle expectation model, read/write scoreboard queues,
// behavioural f4 RAM plus pool unit, and table checks on the first run's read/write logs.
module tb_pool2_ctrl;
  localparam int RD_LAT  = 1;
  localparam int IN_DIM  = 10;
  localparam int OUT_DIM = 5;
  localparam int AW_IN   = 7;
  localparam int AW_OUT  = 5;
  localparam int NREAD   = IN_DIM * IN_DIM;
  localparam int NWIN    = OUT_DIM * OUT_DIM;
  localparam int DCYC    = 102 + RD_LAT;

  typedef struct { int idx; int exp_val; } vec_t;
  typedef struct { int k; int val; } wexp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  pool2_ctrl_if #(.AW_IN(AW_IN), .AW_OUT(AW_OUT)) bus ();

  pool2_ctrl #(.IN_DIM(IN_DIM), .OUT_DIM(OUT_DIM), .AW_IN(AW_IN), .AW_OUT(AW_OUT),
               .RD_LAT(RD_LAT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Run bookkeeping shared by stimulus and monitor.
  int    t0 = 0;
  bit    have_run = 1'b0;
  int    cut_rel = 1 << 30;
  int    rd_cnt = 0, wr_cnt = 0, done_cnt = 0;
  int    rd_log [NREAD];
  int    wr_log [NWIN];
  int    exp_rd [$];
  wexp_t exp_wr [$];

  // f4 RAM holds its own address as data; one pool unit tracks the running max.
  logic [AW_IN-1:0] rd_pipe [RD_LAT];
  logic [RD_LAT-1:0] rv_pipe = '0;
  logic [AW_IN-1:0] pmax = '0;

  always @(posedge clk) begin
    rd_pipe[0] <= bus.f4_raddr;
    rv_pipe[0] <= bus.f4_ren;
    for (int i = 1; i < RD_LAT; i++) begin
      rd_pipe[i] <= rd_pipe[i-1];
      rv_pipe[i] <= rv_pipe[i-1];
    end
    if (rv_pipe[RD_LAT-1]) begin
      if (bus.pool2_clr || rd_pipe[RD_LAT-1] > pmax) pmax <= rd_pipe[RD_LAT-1];
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    int rel;
    bit in_run;
    wexp_t w;
    int a;
    if (!rst_n) begin
      checkOutput("rst_ren", int'(bus.f4_ren), 0);
      checkOutput("rst_busy", int'(bus.pool2_busy), 0);
      checkOutput("rst_done", int'(bus.pool2_done), 0);
      checkOutput("rst_clr", int'(bus.pool2_clr), 0);
      checkOutput("rst_wen", int'(bus.f5_wen), 0);
    end else begin
      rel    = cyc + 1 - t0;
      in_run = have_run && rel >= 1 && rel <= DCYC && rel < cut_rel;
      checkOutput("ren", int'(bus.f4_ren), int'(in_run && rel <= NREAD));
      checkOutput("busy", int'(bus.pool2_busy), int'(in_run));
      checkOutput("done", int'(bus.pool2_done), int'(in_run && rel == DCYC));
      checkOutput("clr", int'(bus.pool2_clr),
                  int'(in_run && rel >= 1 + RD_LAT && rel <= 97 + RD_LAT &&
                       (rel - 1 - RD_LAT) % 4 == 0));
      checkOutput("wen", int'(bus.f5_wen),
                  int'(in_run && rel >= 5 + RD_LAT && rel <= 101 + RD_LAT &&
                       (rel - 5 - RD_LAT) % 4 == 0));
      if (bus.pool2_done) done_cnt++;
      if (bus.f4_ren) begin
        if (exp_rd.size() == 0) checkOutput("raddr_extra", int'(bus.f4_raddr), -1);
        else begin
          a = exp_rd.pop_front();
          checkOutput("raddr", int'(bus.f4_raddr), a);
        end
        if (rd_cnt < NREAD) rd_log[rd_cnt] = int'(bus.f4_raddr);
        rd_cnt++;
      end
      if (bus.f5_wen) begin
        if (exp_wr.size() == 0) checkOutput("waddr_extra", int'(bus.f5_waddr), -1);
        else begin
          w = exp_wr.pop_front();
          checkOutput("waddr", int'(bus.f5_waddr), w.k);
          checkOutput("f5_data", int'(pmax), w.val);
        end
        if (wr_cnt < NWIN) wr_log[wr_cnt] = int'(pmax);
        wr_cnt++;
      end
    end
  end

  // Waits (at posedge+1) until the next edge is relative cycle n of the current run.
  task automatic wait_rel(input int n);
    int guard = 0;
    while (cyc + 1 - t0 != n && guard < 3000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 3000) begin
      total++;
      bad++;
      $display("[TB] FAIL wait_timeout: got no cycle %0d expected it within 3000", n);
    end
  endtask

  // One-cycle start pulse; the model accepts it only when the controller should be idle.
  task automatic applyStimulus();
    int rel_e = cyc + 1 - t0;
    wexp_t w;
    if (!have_run || rel_e > DCYC || rel_e >= cut_rel) begin
      t0       = cyc + 1;
      have_run = 1'b1;
      cut_rel  = 1 << 30;
      rd_cnt   = 0;
      wr_cnt   = 0;
      done_cnt = 0;
      exp_rd.delete();
      exp_wr.delete();
      for (int r = 0; r < OUT_DIM; r++)
        for (int c = 0; c < OUT_DIM; c++) begin
          for (int s = 0; s < 4; s++)
            exp_rd.push_back((2 * r + s / 2) * IN_DIM + 2 * c + s % 2);
          w.k   = r * OUT_DIM + c;
          w.val = (2 * r + 1) * IN_DIM + 2 * c + 1;
          exp_wr.push_back(w);
        end
    end
    bus.pool2_start = 1'b1;
    @(posedge clk);
    #1;
    bus.pool2_start = 1'b0;
  endtask

  task automatic endRun();
    checkOutput("reads_per_run", rd_cnt, NREAD);
    checkOutput("writes_per_run", wr_cnt, NWIN);
    checkOutput("dones_per_run", done_cnt, 1);
    checkOutput("rd_queue_left", exp_rd.size(), 0);
    checkOutput("wr_queue_left", exp_wr.size(), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test expected finish before 200us");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t rd_vec [12];
    vec_t wr_vec [6];
    int   n_before;
    rd_vec = '{'{0, 0}, '{1, 1}, '{2, 10}, '{3, 11}, '{4, 2}, '{5, 3}, '{6, 12}, '{7, 13},
               '{96, 88}, '{97, 89}, '{98, 98}, '{99, 99}};
    wr_vec = '{'{0, 11}, '{1, 13}, '{4, 19}, '{5, 31}, '{12, 55}, '{24, 99}};

    bus.pool2_start = 1'b0;
`ifdef POOL2_ABORT_EN
    bus.pool2_abort = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", int'(bus.pool2_busy), 0);
    checkOutput("reset_done", int'(bus.pool2_done), 0);
    checkOutput("reset_ren", int'(bus.f4_ren), 0);
    checkOutput("reset_raddr", int'(bus.f4_raddr), 0);
    checkOutput("reset_wen", int'(bus.f5_wen), 0);
    checkOutput("reset_waddr", int'(bus.f5_waddr), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] run 1: full layer with ignored start pulses");
    applyStimulus();
    wait_rel(50);
    applyStimulus();
    wait_rel(DCYC);
    applyStimulus();
    for (int i = 0; i < 12; i++)
      checkOutput($sformatf("rd_log[%0d]", rd_vec[i].idx), rd_log[rd_vec[i].idx], rd_vec[i].exp_val);
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("f5[%0d]", wr_vec[i].idx), wr_log[wr_vec[i].idx], wr_vec[i].exp_val);
    endRun();

    $display("[TB] run 2: restart right after done, reset at cycle 40");
    applyStimulus();
    wait_rel(40);
    rst_n    = 1'b0;
    have_run = 1'b0;
    cut_rel  = 40;
    n_before = 0;
    for (int k = 0; k < NWIN; k++) if (5 + RD_LAT + 4 * k < 40) n_before++;
    wait_rel(45);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("writes_before_rst", wr_cnt, n_before);
    checkOutput("reads_before_rst", rd_cnt, 39);
    checkOutput("done_after_rst", done_cnt, 0);

    $display("[TB] run 3: full layer after reset");
    applyStimulus();
    wait_rel(DCYC + 2);
    endRun();

`ifdef POOL2_ABORT_EN
    $display("[TB] run 4: abort at cycle 30");
    applyStimulus();
    wait_rel(30);
    bus.pool2_abort = 1'b1;
    cut_rel = 31;
    @(posedge clk);
    #1;
    bus.pool2_abort = 1'b0;
    wait_rel(DCYC + 2);
    n_before = 0;
    for (int k = 0; k < NWIN; k++) if (5 + RD_LAT + 4 * k <= 30) n_before++;
    checkOutput("abort_writes", wr_cnt, n_before);
    checkOutput("abort_reads", rd_cnt, 30);
    checkOutput("abort_done", done_cnt, 0);
    applyStimulus();
    wait_rel(DCYC + 2);
    endRun();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
